fp_issue_queue: RTL and testbench

Issue queue in front of the floating-point execution unit. It accepts FP instructions from dispatch with up to three source operands, each either a value or a pending ROB tag. It captures pending operands from the common data bus (CDB), and issues the oldest fully-ready entry to the FPU over a valid/ready handshake. It is the upstream, issuing end of the FPU execution-unit input interface.

---
 rtl/fp_issue_queue.sv | 147 ++++++++++++++
 tb/tb_fp_issue_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_queue.sv
// fp_issue_queue: collapsing FP issue queue with CDB wakeup and oldest-ready issue; define LEN5_FP_IQ_BYPASS_EN for same-cycle dispatch bypass
module fp_issue_queue #(
   parameter int DEPTH        = 4,
   parameter int EU_CTL_LEN   = 6,
   parameter int FCSR_FRM_LEN = 3,
   parameter int ROB_IDX_LEN  = 4,
   parameter int FLEN         = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_i,
   input  logic                    dispatch_valid_i,
   output logic                    dispatch_ready_o,
   input  logic [EU_CTL_LEN-1:0]   ctl_i,
   input  logic [FCSR_FRM_LEN-1:0] rm_i,
   input  logic [ROB_IDX_LEN-1:0]  rob_idx_i,
   input  logic                    rs1_ready_i,
   input  logic [ROB_IDX_LEN-1:0]  rs1_rob_idx_i,
   input  logic [FLEN-1:0]         rs1_value_i,
   input  logic                    rs2_ready_i,
   input  logic [ROB_IDX_LEN-1:0]  rs2_rob_idx_i,
   input  logic [FLEN-1:0]         rs2_value_i,
   input  logic                    rs3_ready_i,
   input  logic [ROB_IDX_LEN-1:0]  rs3_rob_idx_i,
   input  logic [FLEN-1:0]         rs3_value_i,
   input  logic                    cdb_valid_i,
   input  logic [ROB_IDX_LEN-1:0]  cdb_rob_idx_i,
   input  logic [FLEN-1:0]         cdb_value_i,
   output logic                    issue_valid_o,
   input  logic                    issue_ready_i,
   output logic [EU_CTL_LEN-1:0]   ctl_o,
   output logic [FCSR_FRM_LEN-1:0] rm_o,
   output logic [ROB_IDX_LEN-1:0]  rob_idx_o,
   output logic [FLEN-1:0]         rs1_value_o,
   output logic [FLEN-1:0]         rs2_value_o,
   output logic [FLEN-1:0]         rs3_value_o,
   output logic                    empty_o
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   logic [CW-1:0]           count_q, count_d, widx;
   logic [IW-1:0]           cand;
   logic [EU_CTL_LEN-1:0]   ctl_q [DEPTH];
   logic [EU_CTL_LEN-1:0]   ctl_d [DEPTH];
   logic [FCSR_FRM_LEN-1:0] rm_q [DEPTH];
   logic [FCSR_FRM_LEN-1:0] rm_d [DEPTH];
   logic [ROB_IDX_LEN-1:0]  rob_q [DEPTH];
   logic [ROB_IDX_LEN-1:0]  rob_d [DEPTH];
   logic [2:0]              rdy_q [DEPTH];
   logic [2:0]              rdy_d [DEPTH];
   logic [ROB_IDX_LEN-1:0]  tag_q [DEPTH][3];
   logic [ROB_IDX_LEN-1:0]  tag_d [DEPTH][3];
   logic [FLEN-1:0]         val_q [DEPTH][3];
   logic [FLEN-1:0]         val_d [DEPTH][3];
   logic [2:0]              in_rdy, in_rdy_s;
   logic [ROB_IDX_LEN-1:0]  in_tag [3];
   logic [FLEN-1:0]         in_val [3];
   logic [FLEN-1:0]         in_val_s [3];
   logic                    found, byp, issued, byp_fire, accept, write;

   // gather dispatched operands and let a concurrent CDB broadcast fill pending ones
   always_comb begin
      in_rdy = {rs3_ready_i, rs2_ready_i, rs1_ready_i};
      in_tag = '{rs1_rob_idx_i, rs2_rob_idx_i, rs3_rob_idx_i};
      in_val = '{rs1_value_i, rs2_value_i, rs3_value_i};
      for (int k = 0; k < 3; k++) begin
         in_rdy_s[k] = in_rdy[k] | (cdb_valid_i && in_tag[k] == cdb_rob_idx_i);
         in_val_s[k] = in_rdy[k] ? in_val[k] : cdb_value_i;
      end
   end

   // pick the oldest valid entry whose three operands are ready
   always_comb begin
      found = 1'b0;
      cand  = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (CW'(i) < count_q && &rdy_q[i]) begin
            found = 1'b1;
            cand  = IW'(i);
         end
   end

`ifdef LEN5_FP_IQ_BYPASS_EN
   assign byp = count_q == '0 && dispatch_valid_i && &in_rdy;
`else
   assign byp = 1'b0;
`endif

   assign issue_valid_o    = (found | byp) & ~flush_i;
   assign issued           = found & issue_ready_i & ~flush_i;
   assign byp_fire         = byp & issue_ready_i & ~flush_i;
   assign dispatch_ready_o = count_q < CW'(DEPTH);
   assign accept           = dispatch_valid_i & dispatch_ready_o & ~flush_i;
   assign write            = accept & ~byp_fire;
   assign widx             = count_q - CW'(issued);
   assign count_d          = flush_i ? '0 : widx + CW'(write);
   assign empty_o          = count_q == '0;
   assign ctl_o            = found ? ctl_q[cand] : byp ? ctl_i : '0;
   assign rm_o             = found ? rm_q[cand] : byp ? rm_i : '0;
   assign rob_idx_o        = found ? rob_q[cand] : byp ? rob_idx_i : '0;
   assign rs1_value_o      = found ? val_q[cand][0] : byp ? rs1_value_i : '0;
   assign rs2_value_o      = found ? val_q[cand][1] : byp ? rs2_value_i : '0;
   assign rs3_value_o      = found ? val_q[cand][2] : byp ? rs3_value_i : '0;

   // collapse above the issued slot, apply CDB wakeup at the shifted position, append dispatch
   always_comb begin
      logic [IW-1:0] src;
      logic          wake;
      src  = '0;
      wake = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         src      = (issued && IW'(i) >= cand && i < DEPTH - 1) ? IW'(i + 1) : IW'(i);
         ctl_d[i] = ctl_q[src];
         rm_d[i]  = rm_q[src];
         rob_d[i] = rob_q[src];
         for (int k = 0; k < 3; k++) begin
            wake        = cdb_valid_i && !rdy_q[src][k] && tag_q[src][k] == cdb_rob_idx_i;
            rdy_d[i][k] = rdy_q[src][k] | wake;
            tag_d[i][k] = tag_q[src][k];
            val_d[i][k] = wake ? cdb_value_i : val_q[src][k];
         end
         if (write && CW'(i) == widx) begin
            ctl_d[i] = ctl_i;
            rm_d[i]  = rm_i;
            rob_d[i] = rob_idx_i;
            rdy_d[i] = in_rdy_s;
            tag_d[i] = in_tag;
            val_d[i] = in_val_s;
         end
      end
   end

   // occupancy counter; reset and flush both empty the queue
   always_ff @(posedge clk_i)
      if (rst_i) count_q <= '0;
      else count_q <= count_d;

   // entry payload needs no reset since validity comes from the counter
   always_ff @(posedge clk_i) begin
      ctl_q <= ctl_d;
      rm_q  <= rm_d;
      rob_q <= rob_d;
      rdy_q <= rdy_d;
      tag_q <= tag_d;
      val_q <= val_d;
   end
endmodule

// File: tb/tb_fp_issue_queue.sv
// tb_fp_issue_queue: randomized scoreboard bench for fp_issue_queue against a queue-based reference model
module tb_fp_issue_queue;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic             dv;
      logic [5:0]       ctl;
      logic [2:0]       rm;
      logic [3:0]       rob;
      logic [2:0]       rrdy;
      logic [2:0][3:0]  rtag;
      logic [2:0][63:0] rval;
      logic             cv;
      logic [3:0]       ctag;
      logic [63:0]      cval;
      logic             ir;
      logic             fl;
   } stim_t;

   typedef struct packed {
      logic [5:0]       ctl;
      logic [2:0]       rm;
      logic [3:0]       rob;
      logic [2:0]       rdy;
      logic [2:0][3:0]  tag;
      logic [2:0][63:0] val;
   } ent_t;

   typedef struct packed {
      logic             valid;
      logic             drdy;
      logic             empty;
      logic             dchk;
      logic [5:0]       ctl;
      logic [2:0]       rm;
      logic [3:0]       rob;
      logic [2:0][63:0] val;
   } exp_t;

   logic        clk, rst, flush, dispatch_valid, dispatch_ready, issue_valid, issue_ready, empty;
   logic [5:0]  ctl, ctl_out;
   logic [2:0]  rm, rm_out;
   logic [3:0]  rob, rob_out, rs1_tag, rs2_tag, rs3_tag, cdb_tag;
   logic        rs1_ready, rs2_ready, rs3_ready, cdb_valid;
   logic [63:0] rs1_val, rs2_val, rs3_val, cdb_val, rs1_out, rs2_out, rs3_out;

   ent_t mq[$];
   exp_t exp_q[$];
   exp_t me;
   int   checks = 0;
   int   errors = 0;

   fp_issue_queue dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .dispatch_valid_i(dispatch_valid), .dispatch_ready_o(dispatch_ready),
      .ctl_i(ctl), .rm_i(rm), .rob_idx_i(rob),
      .rs1_ready_i(rs1_ready), .rs1_rob_idx_i(rs1_tag), .rs1_value_i(rs1_val),
      .rs2_ready_i(rs2_ready), .rs2_rob_idx_i(rs2_tag), .rs2_value_i(rs2_val),
      .rs3_ready_i(rs3_ready), .rs3_rob_idx_i(rs3_tag), .rs3_value_i(rs3_val),
      .cdb_valid_i(cdb_valid), .cdb_rob_idx_i(cdb_tag), .cdb_value_i(cdb_val),
      .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
      .ctl_o(ctl_out), .rm_o(rm_out), .rob_idx_o(rob_out),
      .rs1_value_o(rs1_out), .rs2_value_o(rs2_out), .rs3_value_o(rs3_out),
      .empty_o(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: one expected record per cycle, compared mid-cycle
   always @(negedge clk)
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         chk("issue_valid", 64'(issue_valid), 64'(me.valid));
         chk("dispatch_ready", 64'(dispatch_ready), 64'(me.drdy));
         chk("empty", 64'(empty), 64'(me.empty));
         if (me.dchk) begin
            chk("ctl", 64'(ctl_out), 64'(me.ctl));
            chk("rm", 64'(rm_out), 64'(me.rm));
            chk("rob_idx", 64'(rob_out), 64'(me.rob));
            chk("rs1_value", rs1_out, me.val[0]);
            chk("rs2_value", rs2_out, me.val[1]);
            chk("rs3_value", rs3_out, me.val[2]);
         end
      end

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t rnd();
      stim_t s;
      s.dv   = $urandom_range(0, 9) < 6;
      s.ctl  = 6'($urandom);
      s.rm   = 3'($urandom);
      s.rob  = 4'($urandom);
      for (int k = 0; k < 3; k++) begin
         s.rrdy[k] = 1'($urandom_range(0, 1));
         s.rtag[k] = 4'($urandom_range(0, 7));
         s.rval[k] = {$urandom, $urandom};
      end
      s.cv   = $urandom_range(0, 9) < 5;
      s.ctag = 4'($urandom_range(0, 7));
      s.cval = {$urandom, $urandom};
      s.ir   = $urandom_range(0, 9) < 7;
      s.fl   = $urandom_range(0, 59) == 0;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      dispatch_valid = s.dv;
      ctl = s.ctl; rm = s.rm; rob = s.rob;
      rs1_ready = s.rrdy[0]; rs1_tag = s.rtag[0]; rs1_val = s.rval[0];
      rs2_ready = s.rrdy[1]; rs2_tag = s.rtag[1]; rs2_val = s.rval[1];
      rs3_ready = s.rrdy[2]; rs3_tag = s.rtag[2]; rs3_val = s.rval[2];
      cdb_valid = s.cv; cdb_tag = s.ctag; cdb_val = s.cval;
      issue_ready = s.ir; flush = s.fl;
   endtask

   // drive one cycle, predict this cycle's outputs, advance the reference queue
   task automatic step(input stim_t s);
      int   c;
      bit   byp, fire;
      exp_t e;
      ent_t t;
      apply(s);
      c = -1;
      foreach (mq[i]) if (c < 0 && &mq[i].rdy) c = i;
`ifdef LEN5_FP_IQ_BYPASS_EN
      byp = mq.size() == 0 && s.dv && &s.rrdy;
`else
      byp = 1'b0;
`endif
      e = '0;
      e.valid = (c >= 0 || byp) && !s.fl;
      e.drdy  = mq.size() < DEPTH;
      e.empty = mq.size() == 0;
      e.dchk  = e.valid;
      if (c >= 0) begin
         e.ctl = mq[c].ctl; e.rm = mq[c].rm; e.rob = mq[c].rob; e.val = mq[c].val;
      end else if (byp) begin
         e.ctl = s.ctl; e.rm = s.rm; e.rob = s.rob; e.val = s.rval;
      end
      exp_q.push_back(e);
      fire = e.valid && s.ir;
      if (s.fl) mq.delete();
      else begin
         if (fire && c >= 0) mq.delete(c);
         foreach (mq[i]) begin
            t = mq[i];
            for (int k = 0; k < 3; k++)
               if (!t.rdy[k] && s.cv && t.tag[k] == s.ctag) begin
                  t.rdy[k] = 1'b1;
                  t.val[k] = s.cval;
               end
            mq[i] = t;
         end
         if (s.dv && e.drdy && !(fire && byp)) begin
            t.ctl = s.ctl; t.rm = s.rm; t.rob = s.rob; t.tag = s.rtag;
            for (int k = 0; k < 3; k++) begin
               t.rdy[k] = s.rrdy[k] || (s.cv && s.rtag[k] == s.ctag);
               t.val[k] = s.rrdy[k] ? s.rval[k] : s.cval;
            end
            mq.push_back(t);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      stim_t s;
      exp_t  e;
      rst = 1'b1;
      apply(idle());
      repeat (2) @(posedge clk);
      #1;
      e = '0; e.drdy = 1'b1; e.empty = 1'b1; e.dchk = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // all-ready FPU_ADD_D with rob_idx 3
      s = idle(); s.dv = 1; s.ctl = 6'd1; s.rob = 4'd3; s.rrdy = 3'b111; s.rval[0] = 64'h3ff0_0000_0000_0000; step(s);
      s = idle(); s.ir = 1; step(s); step(s);
      // older waiting A, younger ready B, then wake A via CDB tag 5
      s = idle(); s.dv = 1; s.rob = 4'd1; s.rrdy = 3'b110; s.rtag[0] = 4'd5; s.ir = 1; step(s);
      s = idle(); s.dv = 1; s.rob = 4'd2; s.rrdy = 3'b111; s.ir = 1; step(s);
      s = idle(); s.ir = 1; step(s);
      s = idle(); s.cv = 1; s.ctag = 4'd5; s.cval = 64'h4000_0000_0000_0000; s.ir = 1; step(s);
      s = idle(); s.ir = 1; step(s); step(s);
      // fill with waiting entries, fifth refused, then one wakes and issues
      for (int i = 0; i < 5; i++) begin
         s = idle(); s.dv = 1; s.rob = 4'(8 + i);
         for (int k = 0; k < 3; k++) s.rtag[k] = 4'(8 + i);
         step(s);
      end
      s = idle(); s.cv = 1; s.ctag = 4'd8; s.cval = 64'h55; step(s);
      s = idle(); s.ir = 1; step(s);
      s = idle(); step(s);
      s = idle(); s.fl = 1; step(s);
      // insertion snoop on rs2 tag 7
      s = idle(); s.dv = 1; s.rob = 4'd6; s.rrdy = 3'b101; s.rtag[1] = 4'd7; s.cv = 1; s.ctag = 4'd7; s.cval = 64'h1; step(s);
      s = idle(); s.ir = 1; step(s); step(s);
      // issue middle entry while dispatching D
      s = idle(); s.dv = 1; s.rob = 4'd1; s.rtag = {4'd13, 4'd13, 4'd13}; step(s);
      s = idle(); s.dv = 1; s.rob = 4'd2; s.rrdy = 3'b111; s.rval[2] = 64'hab; step(s);
      s = idle(); s.dv = 1; s.rob = 4'd3; s.rtag = {4'd14, 4'd14, 4'd14}; step(s);
      s = idle(); s.dv = 1; s.rob = 4'd4; s.rtag = {4'd15, 4'd15, 4'd15}; s.ir = 1; step(s);
      s = idle(); s.cv = 1; s.ctag = 4'd14; s.cval = 64'h77; step(s);
      s = idle(); s.ir = 1; step(s); step(s);
      // flush with ready entries and a concurrent dispatch
      s = idle(); s.fl = 1; step(s);
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.dv = 1; s.rob = 4'(i); s.rrdy = 3'b111; step(s);
      end
      s = idle(); s.fl = 1; s.dv = 1; s.rob = 4'd9; s.rrdy = 3'b111; s.ir = 1; step(s);
      s = idle(); s.ir = 1; step(s);
      repeat (3000) step(rnd());
      s = idle(); s.fl = 1; step(s);
      step(idle());
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d records pending, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
